// File: rtl/ob_pkg.sv
// Shared order-book types: table entry payload and the tagged reject response.
// No ports; imported by the reject egress top and its FIFO.
package ob_pkg;

    localparam int unsigned UID_W   = 16;
    localparam int unsigned QTY_W   = 16;
    localparam int unsigned PRICE_W = 32;
    localparam int unsigned CNT_W   = 16;

    typedef logic [UID_W-1:0]   uid_t;
    typedef logic [QTY_W-1:0]   quantity_t;
    typedef logic [PRICE_W-1:0] price_t;

    typedef struct packed {
        uid_t      uid;
        price_t    price;
        quantity_t quantity;
    } table_t;

    typedef struct packed {
        logic   is_ask;
        table_t rej;
    } reject_rsp_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/ob_reject_fifo.sv
// N-entry synchronous FIFO of tagged rejects with registered empty/full flags.
// Ports:
//   clk, rst      clock, async active-high reset
//   push, din     write din at the write pointer (caller guarantees !full_r)
//   pop           advance the read pointer (caller guarantees !empty_r)
//   head          entry at the read pointer (mux of flops only)
//   empty_r/full_r registered occupancy flags
module ob_reject_fifo
    import ob_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  reject_rsp_t din,
    input  logic        pop,
    output reject_rsp_t head,
    output logic        empty_r,
    output logic        full_r
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned OW = AW + 1;

    reject_rsp_t   mem [N];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_nxt;

    // Occupancy is unchanged when push and pop coincide.
    always_comb begin
        occ_nxt = occ;
        if (push && !pop) begin
            occ_nxt = occ + OW'(1);
        end else if (pop && !push) begin
            occ_nxt = occ - OW'(1);
        end
    end

    // Pointers wrap naturally since N is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            occ     <= occ_nxt;
            empty_r <= (occ_nxt == '0);
            full_r  <= (occ_nxt == OW'(N));
        end
    end

    // Storage carries no reset; contents are ignored while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ob_reject_egress.sv
// Drains bid and ask table reject queues under round-robin arbitration into a
// small FIFO and presents them on a registered valid/accept response port.
// Ports:
//   clk, rst                          clock, async active-high reset
//   bid_/ask_reject_valid_r, _reject  table head status and payload
//   bid_/ask_reject_pop               consume table head (combinational)
//   rsp_valid_r, rsp_is_ask_r, rsp_reject_r, rsp_accept  response handshake
//   empty_r, full_r                   FIFO flags
//   rsp_cnt_r                         saturating delivered-reject count
module ob_reject_egress
    import ob_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bid_reject_valid_r,
    input  table_t           bid_reject,
    output logic             bid_reject_pop,
    input  logic             ask_reject_valid_r,
    input  table_t           ask_reject,
    output logic             ask_reject_pop,
    output logic             rsp_valid_r,
    output logic             rsp_is_ask_r,
    output table_t           rsp_reject_r,
    input  logic             rsp_accept,
    output logic             empty_r,
    output logic             full_r,
    output logic [CNT_W-1:0] rsp_cnt_r
);

    logic        prio_ask_r;
    logic        prio_ask_nxt;
    logic        gnt_bid;
    logic        gnt_ask;
    logic        deq;
    reject_rsp_t push_data;
    reject_rsp_t head;

    // Round-robin grant; the full decision uses the registered flag only,
    // and pops are held low while reset is asserted.
    always_comb begin
        gnt_bid      = 1'b0;
        gnt_ask      = 1'b0;
        prio_ask_nxt = prio_ask_r;
        if (!rst && !full_r) begin
            if (bid_reject_valid_r && (!ask_reject_valid_r || !prio_ask_r)) begin
                gnt_bid = 1'b1;
            end else if (ask_reject_valid_r) begin
                gnt_ask = 1'b1;
            end
        end
        if (gnt_bid) begin
            prio_ask_nxt = 1'b1;
        end else if (gnt_ask) begin
            prio_ask_nxt = 1'b0;
        end
    end

    always_comb begin
        push_data.is_ask = gnt_ask;
        push_data.rej    = gnt_ask ? ask_reject : bid_reject;
    end

    assign bid_reject_pop = gnt_bid;
    assign ask_reject_pop = gnt_ask;
    assign deq            = !empty_r && rsp_accept;

    ob_reject_fifo #(.N(N)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (gnt_bid || gnt_ask),
        .din     (push_data),
        .pop     (deq),
        .head    (head),
        .empty_r (empty_r),
        .full_r  (full_r)
    );

    assign rsp_valid_r  = !empty_r;
    assign rsp_is_ask_r = head.is_ask;
    assign rsp_reject_r = head.rej;

    // Arbiter priority and saturating delivery counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_ask_r <= 1'b0;
            rsp_cnt_r  <= '0;
        end else begin
            prio_ask_r <= prio_ask_nxt;
            if (deq && (rsp_cnt_r != CNT_MAX)) begin
                rsp_cnt_r <= rsp_cnt_r + CNT_W'(1);
            end
        end
    end

endmodule
